// File: rtl/palette_encoder.sv
// Nearest-colour encoder: maps a 12-bit RGB pixel to the index of the closest entry
// (minimum sum of absolute differences) in a programmable 16-entry palette.
module palette_encoder #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_red,
  input  logic [3:0]  in_green,
  input  logic [3:0]  in_blue,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_index,
  output logic        out_exact,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [11:0] pal_data,
  output logic        pal_busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state;
  logic [11:0] pal [16];
  logic [11:0] pixel;
  logic [3:0]  k;
  logic [5:0]  best_sad;
  logic [3:0]  best_idx;

  function automatic logic [11:0] default_entry(input logic [3:0] idx);
    case (idx)
      4'd2, 4'd7:       return 12'hAAA;
      4'd3, 4'd4, 4'd8: return 12'hBBB;
      4'd13:            return 12'hCBB;
      default:          return 12'hCCC;
    endcase
  endfunction

  function automatic logic [5:0] absdiff(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? {2'b00, a - b} : {2'b00, b - a};
  endfunction

  // NOTE: the palette is a small register file whose reset value is functional
  // (defaults reload on reset), so every entry is reset, unlike a plain RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) pal[i] <= default_entry(4'(i));
    end else if (pal_we && state == IDLE) begin
      pal[pal_addr] <= pal_data;
    end
  end

  logic [11:0] entry;
  logic [5:0]  sad;
  logic        better;
  logic [5:0]  nxt_sad;
  logic [3:0]  nxt_idx;
  logic        last;

  assign entry   = pal[k];
  assign sad     = absdiff(pixel[11:8], entry[11:8])
                 + absdiff(pixel[7:4],  entry[7:4])
                 + absdiff(pixel[3:0],  entry[3:0]);
  // Strict less-than: on a tie the earlier (lower) index keeps the win.
  assign better  = sad < best_sad;
  assign nxt_sad = better ? sad : best_sad;
  assign nxt_idx = better ? k   : best_idx;
  assign last    = (k == 4'd15) || (EARLY_EXIT && sad == 6'd0);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_index <= 4'd0;
      out_exact <= 1'b0;
      pal_busy  <= 1'b0;
      pixel     <= 12'd0;
      k         <= 4'd0;
      best_sad  <= 6'd63;
      best_idx  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pixel    <= {in_red, in_green, in_blue};
            best_sad <= 6'd63;
            best_idx <= 4'd0;
            k        <= 4'd0;
            in_ready <= 1'b0;
            pal_busy <= 1'b1;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          best_sad <= nxt_sad;
          best_idx <= nxt_idx;
          k        <= k + 4'd1;
          if (last) begin
            out_valid <= 1'b1;
            out_index <= nxt_idx;
            out_exact <= (nxt_sad == 6'd0);
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            pal_busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palette_encoder.sv
// Directed bench for palette_encoder: two instances (early exit on/off) share stimulus
// and are checked against hand-computed indices, exact flags and latencies.
module tb_palette_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_red = '0, in_green = '0, in_blue = '0;
  logic        out_ready = 1'b0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [11:0] pal_data = '0;

  logic        in_ready1, out_valid1, out_exact1, pal_busy1;
  logic [3:0]  out_index1;
  logic        in_ready0, out_valid0, out_exact0, pal_busy0;
  logic [3:0]  out_index0;

  int errors = 0;
  int checks = 0;
  int lat1, lat0;

  always #5 clk = ~clk;

  palette_encoder #(.EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_index(out_index1), .out_exact(out_exact1),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .pal_busy(pal_busy1)
  );

  palette_encoder #(.EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_index(out_index0), .out_exact(out_exact0),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .pal_busy(pal_busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one pixel (optionally with a palette write in the same cycle) and count
  // cycles from the accepting edge until each instance raises out_valid.
  task automatic run_pixel(input logic [11:0] px, input logic we, input logic [3:0] wa,
                           input logic [11:0] wd, output int l1, output int l0);
    @(negedge clk);
    in_valid = 1'b1;
    {in_red, in_green, in_blue} = px;
    pal_we = we; pal_addr = wa; pal_data = wd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pal_we   = 1'b0;
    l1 = 0;
    l0 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid1 && l1 == 0) l1 = c;
      if (out_valid0 && l0 == 0) l0 = c;
      if (l1 != 0 && l0 != 0) break;
      @(posedge clk);
    end
  endtask

  task automatic handshake;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic check_both(input string tag, input int idx, input int exact,
                            input int exp_l1, input int exp_l0);
    check({tag, "_idx_ee1"},   32'(out_index1), idx);
    check({tag, "_exact_ee1"}, 32'(out_exact1), exact);
    check({tag, "_lat_ee1"},   lat1, exp_l1);
    check({tag, "_idx_ee0"},   32'(out_index0), idx);
    check({tag, "_exact_ee0"}, 32'(out_exact0), exact);
    check({tag, "_lat_ee0"},   lat0, exp_l0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready1), 1);
    check("rst_out_valid", 32'(out_valid1), 0);
    check("rst_out_index", 32'(out_index1), 0);
    check("rst_out_exact", 32'(out_exact1), 0);
    check("rst_pal_busy",  32'(pal_busy1), 0);
    reset = 1'b0;

    // Exact hit on entry 0 and on entry 2
    run_pixel(12'hCCC, 1'b0, 4'd0, 12'h000, lat1, lat0);
    check_both("ccc", 0, 1, 2, 17);
    check("ccc_no_ready", 32'(in_ready1), 0);
    handshake();
    run_pixel(12'hAAA, 1'b0, 4'd0, 12'h000, lat1, lat0);
    check_both("aaa", 2, 1, 4, 17);
    handshake();

    // Tie between entries 0 and 13 (SAD 1) resolves to the lower index
    run_pixel(12'hCBC, 1'b0, 4'd0, 12'h000, lat1, lat0);
    check_both("cbc_tie", 0, 0, 17, 17);
    handshake();
    run_pixel(12'h000, 1'b0, 4'd0, 12'h000, lat1, lat0);
    check_both("black", 2, 0, 17, 17);
    handshake();

    // Palette write in IDLE, then the written colour becomes an exact last-entry hit
    @(negedge clk);
    check("idle_not_busy", 32'(pal_busy1), 0);
    pal_we = 1'b1; pal_addr = 4'd15; pal_data = 12'h000;
    @(posedge clk);
    #1 pal_we = 1'b0;
    run_pixel(12'h000, 1'b0, 4'd0, 12'h000, lat1, lat0);
    check_both("wr15", 15, 1, 17, 17);
    handshake();

    // Write to entry 0 while a search is running must be ignored
    @(negedge clk);
    in_valid = 1'b1; {in_red, in_green, in_blue} = 12'h555;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("search_busy", 32'(pal_busy1), 1);
    check("search_no_ready", 32'(in_ready1), 0);
    pal_we = 1'b1; pal_addr = 4'd0; pal_data = 12'h000;
    @(posedge clk);
    #1 pal_we = 1'b0;
    repeat (20) @(posedge clk);
    handshake();
    run_pixel(12'h000, 1'b0, 4'd0, 12'h000, lat1, lat0);
    check_both("busy_wr_ignored", 15, 1, 17, 17);
    handshake();

    // Backpressure: DONE is held and outputs stay put
    run_pixel(12'hAAA, 1'b0, 4'd0, 12'h000, lat1, lat0);
    check_both("bp", 2, 1, 4, 17);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid1), 1);
      check("bp_index", 32'(out_index1), 2);
      check("bp_ready", 32'(in_ready1), 0);
    end
    handshake();
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready1), 1);
    check("bp_release_valid", 32'(out_valid1), 0);

    // Same-cycle palette write and pixel: the search must see the new entry 1
    run_pixel(12'h000, 1'b1, 4'd1, 12'h000, lat1, lat0);
    check_both("wr_same_cycle", 1, 1, 3, 17);
    handshake();

    // Reset during a search at T+6: result dropped, palette defaults restored
    @(negedge clk);
    in_valid = 1'b1; {in_red, in_green, in_blue} = 12'h000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_valid", 32'(out_valid1 | out_valid0), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(in_ready1), 1);
    check("rst_mid_busy",  32'(pal_busy1), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_mid_no_valid", 32'(out_valid1 | out_valid0), 0);
    end
    run_pixel(12'h000, 1'b0, 4'd0, 12'h000, lat1, lat0);
    check_both("rst_defaults", 2, 0, 17, 17);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
